// File: rtl/keccak_seq_pkg.sv
// -----------------------------------------------------------------------------
// keccak_seq_pkg
// Shared types and constants for the keccak stream sequencer.
//   seq_state_e : sequencer FSM states
//   SZ_*        : out_size encodings understood by the keccak core
//   BYTES_FULL  : s_bytes / byte_num encoding for a complete 4-byte word
// -----------------------------------------------------------------------------
package keccak_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CORE_RST = 3'd1,
        FEED     = 3'd2,
        PAD      = 3'd3,
        WAIT_OUT = 3'd4,
        DONE     = 3'd5
    } seq_state_e;

    localparam logic [1:0] SZ_224 = 2'd0;
    localparam logic [1:0] SZ_256 = 2'd1;
    localparam logic [1:0] SZ_384 = 2'd2;
    localparam logic [1:0] SZ_512 = 2'd3;

    localparam logic [1:0] BYTES_FULL = 2'd0;

endpackage

// File: rtl/keccak_seq_timer.sv
// -----------------------------------------------------------------------------
// keccak_seq_timer
// Saturating watchdog counter used while the sequencer waits for the digest.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : force the count to zero (has priority over enable_i)
//   enable_i    : count one per cycle until LIMIT is reached
//   expired_o   : high while the count equals LIMIT
// -----------------------------------------------------------------------------
module keccak_seq_timer #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned   CW      = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up and hold at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i && (count_q != LIMIT_C)) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT_C);

endmodule

// File: rtl/keccak_stream_sequencer.sv
// -----------------------------------------------------------------------------
// keccak_stream_sequencer
// Drives one keccak core from a 32-bit valid/ready message stream: resets the
// core at the start of each message, forwards words while the core buffer has
// room, turns the final word into the core's is_last/byte_num encoding (adding
// an empty pad word after a full final word), then captures the digest and
// offers it on a valid/ready output.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cfg_out_size                    digest size, latched when a message starts
//   s_data/s_valid/s_ready          message word stream (first byte in [31:24])
//   s_last/s_bytes                  end of message, valid bytes in last word
//   core_reset, core_in,            keccak core control / data
//   core_in_ready, core_is_last,
//   core_byte_num, core_out_size
//   core_buffer_full, core_out,     keccak core status / digest
//   core_out_ready
//   dig_data/dig_valid/dig_ready    captured digest stream
//   busy                            high whenever the FSM is not in IDLE
//   err_timeout                     watchdog pulse (KECCAK_SEQ_TIMEOUT_EN only)
//
// Build option: define KECCAK_SEQ_TIMEOUT_EN to add the WAIT_OUT watchdog, the
// TIMEOUT_CYCLES parameter and the err_timeout port. Without it the sequencer
// waits for the digest indefinitely.
// -----------------------------------------------------------------------------
module keccak_stream_sequencer
    import keccak_seq_pkg::*;
#(
    parameter int unsigned DIGEST_W = 512
`ifdef KECCAK_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          cfg_out_size,
    input  logic [31:0]         s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_last,
    input  logic [1:0]          s_bytes,
    output logic                core_reset,
    output logic [31:0]         core_in,
    output logic                core_in_ready,
    output logic                core_is_last,
    output logic [1:0]          core_byte_num,
    input  logic                core_buffer_full,
    input  logic [DIGEST_W-1:0] core_out,
    input  logic                core_out_ready,
    output logic [1:0]          core_out_size,
    output logic [DIGEST_W-1:0] dig_data,
    output logic                dig_valid,
    input  logic                dig_ready,
    output logic                busy
`ifdef KECCAK_SEQ_TIMEOUT_EN
    ,
    output logic                err_timeout
`endif
);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic                core_reset_q;
    logic [1:0]          out_size_q;
    logic [DIGEST_W-1:0] dig_data_q;
    logic                dig_valid_q;
    logic                word_fire_s;
    logic                tmo_fire_s;

    // A stream word is handed to the core only when the core can take it.
    assign word_fire_s = (state_q == FEED) && s_valid && !core_buffer_full;

`ifdef KECCAK_SEQ_TIMEOUT_EN
    logic tmo_expired_s;

    keccak_seq_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != WAIT_OUT),
        .enable_i  (state_q == WAIT_OUT),
        .expired_o (tmo_expired_s)
    );

    // A digest arriving on the expiry cycle still wins over the timeout.
    assign tmo_fire_s  = (state_q == WAIT_OUT) && !core_out_ready && tmo_expired_s;
    assign err_timeout = tmo_fire_s;
`else
    assign tmo_fire_s = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    state_d = CORE_RST;
                end else begin
                    state_d = IDLE;
                end
            end
            CORE_RST: begin
                state_d = FEED;
            end
            FEED: begin
                if (word_fire_s && s_last) begin
                    // A full final word cannot carry is_last; it needs a pad word.
                    if (s_bytes != BYTES_FULL) begin
                        state_d = WAIT_OUT;
                    end else begin
                        state_d = PAD;
                    end
                end else begin
                    state_d = FEED;
                end
            end
            PAD: begin
                if (!core_buffer_full) begin
                    state_d = WAIT_OUT;
                end else begin
                    state_d = PAD;
                end
            end
            WAIT_OUT: begin
                if (core_out_ready) begin
                    state_d = DONE;
                end else if (tmo_fire_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_OUT;
                end
            end
            DONE: begin
                if (dig_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core-side and stream-side handshake outputs; words pass through unregistered.
    always_comb begin
        s_ready       = 1'b0;
        core_in       = 32'd0;
        core_in_ready = 1'b0;
        core_is_last  = 1'b0;
        core_byte_num = 2'd0;
        case (state_q)
            FEED: begin
                s_ready       = !core_buffer_full;
                core_in       = s_data;
                core_in_ready = word_fire_s;
                if (word_fire_s && s_last && (s_bytes != BYTES_FULL)) begin
                    core_is_last  = 1'b1;
                    core_byte_num = s_bytes;
                end else begin
                    core_is_last  = 1'b0;
                    core_byte_num = 2'd0;
                end
            end
            PAD: begin
                // Empty final word: is_last with byte_num 0 and zero data.
                if (!core_buffer_full) begin
                    core_in_ready = 1'b1;
                    core_is_last  = 1'b1;
                end else begin
                    core_in_ready = 1'b0;
                    core_is_last  = 1'b0;
                end
            end
            default: begin
                s_ready = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Core reset: held during our own reset, one pulse per message, and after a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset_q <= 1'b1;
        end else begin
            core_reset_q <= (state_d == CORE_RST) || tmo_fire_s;
        end
    end

    // Digest size latch, sampled only when a new message begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_size_q <= SZ_224;
        end else if ((state_q == IDLE) && s_valid) begin
            out_size_q <= cfg_out_size;
        end else begin
            out_size_q <= out_size_q;
        end
    end

    // Digest capture and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            dig_data_q  <= {DIGEST_W{1'b0}};
            dig_valid_q <= 1'b0;
        end else if ((state_q == WAIT_OUT) && core_out_ready) begin
            dig_data_q  <= core_out;
            dig_valid_q <= 1'b1;
        end else if ((state_q == DONE) && dig_ready) begin
            dig_valid_q <= 1'b0;
        end else begin
            dig_valid_q <= dig_valid_q;
        end
    end

    assign core_reset    = core_reset_q;
    assign core_out_size = out_size_q;
    assign dig_data      = dig_data_q;
    assign dig_valid     = dig_valid_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_keccak_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_keccak_stream_sequencer
// Directed, table-driven bench. A behavioural core stand-in records every word
// the sequencer issues, applies buffer_full stalls on request, and returns a
// digest built from what it saw (xor of words, word count, out_size, byte_num)
// so dropped, duplicated or mis-encoded words change the digest.
// -----------------------------------------------------------------------------
module tb_keccak_stream_sequencer;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    cfg_out_size = 2'd0;
    logic [31:0]   s_data = 32'd0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [1:0]    s_bytes = 2'd0;
    logic          core_reset;
    logic [31:0]   core_in;
    logic          core_in_ready;
    logic          core_is_last;
    logic [1:0]    core_byte_num;
    logic          core_buffer_full = 1'b0;
    logic [DW-1:0] core_out = '0;
    logic          core_out_ready = 1'b0;
    logic [1:0]    core_out_size;
    logic [DW-1:0] dig_data;
    logic          dig_valid;
    logic          dig_ready = 1'b0;
    logic          busy;
`ifdef KECCAK_SEQ_TIMEOUT_EN
    logic          err_timeout;
`endif

    always #5 clk = ~clk;

    keccak_stream_sequencer #(
        .DIGEST_W (DW)
`ifdef KECCAK_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (16)
`endif
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_out_size     (cfg_out_size),
        .s_data           (s_data),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_last           (s_last),
        .s_bytes          (s_bytes),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .core_out_size    (core_out_size),
        .dig_data         (dig_data),
        .dig_valid        (dig_valid),
        .dig_ready        (dig_ready),
        .busy             (busy)
`ifdef KECCAK_SEQ_TIMEOUT_EN
        ,
        .err_timeout      (err_timeout)
`endif
    );

    typedef struct {
        logic [31:0] w0;        // first word; later words are w0 ^ i*0x01010101
        int          n;         // words in message
        logic [1:0]  bytes;     // s_bytes on final word
        logic [1:0]  os;        // cfg_out_size
        int          stall_at;  // raise buffer_full after this many core words (0 = never)
        int          stall_len; // buffer_full length in cycles
        int          hold;      // cycles dig_ready is held low
        int          exp_fires; // words the core must see, pad included
        logic [1:0]  exp_bn;    // byte_num on the is_last word
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } beat_t;

    vec_t  tbl[6];
    beat_t expq[$];
    beat_t mb;

    int checks = 0;
    int errors = 0;

    // core model state
    int          rst_pulses = 0;
    int          viol = 0;
    int          stream_err = 0;
    int          stall_cnt = 0;
    int          m_lat = 0;
    logic [15:0] m_fires = 16'd0;
    logic [31:0] m_xor = 32'd0;
    logic        m_done = 1'b0;
    logic [1:0]  m_bn = 2'd0;
    logic [1:0]  m_os = 2'd0;
    int          cur_stall_at = 0;
    int          cur_stall_len = 0;
    logic        no_out = 1'b0;

    function automatic logic [DW-1:0] mk_digest(input logic [31:0] x, input logic [15:0] f,
                                                input logic [1:0] os, input logic [1:0] bn);
        return {{14{x}}, ~x, f, 6'd0, os, 6'd0, bn};
    endfunction

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        return v.w0 ^ (32'(i) * 32'h01010101);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural keccak core: logs words, injects stalls, returns a digest.
    always @(posedge clk) begin
        if (core_buffer_full && (core_in_ready || s_ready)) viol <= viol + 1;
        if (core_reset) begin
            rst_pulses       <= rst_pulses + 1;
            m_fires          <= 16'd0;
            m_xor            <= 32'd0;
            m_done           <= 1'b0;
            m_lat            <= 0;
            stall_cnt        <= 0;
            core_buffer_full <= 1'b0;
            core_out_ready   <= 1'b0;
            core_out         <= '0;
        end else begin
            if (stall_cnt != 0) begin
                stall_cnt        <= stall_cnt - 1;
                core_buffer_full <= (stall_cnt != 1);
            end
            if (core_in_ready) begin
                m_fires <= m_fires + 16'd1;
                m_xor   <= m_xor ^ core_in;
                if (expq.size() == 0) begin
                    stream_err <= stream_err + 1;
                end else begin
                    mb = expq.pop_front();
                    if (mb.w !== core_in || mb.last !== core_is_last || mb.bn !== core_byte_num)
                        stream_err <= stream_err + 1;
                end
                if (core_is_last) begin
                    m_done <= 1'b1;
                    m_bn   <= core_byte_num;
                    m_os   <= core_out_size;
                    m_lat  <= 4;
                end
                if (int'(m_fires) + 1 == cur_stall_at) begin
                    stall_cnt        <= cur_stall_len;
                    core_buffer_full <= 1'b1;
                end
            end
            if (m_done && !no_out && !core_out_ready) begin
                if (m_lat > 1) begin
                    m_lat <= m_lat - 1;
                end else begin
                    core_out_ready <= 1'b1;
                    core_out       <= mk_digest(m_xor, m_fires, m_os, m_bn);
                end
            end
        end
    end

    // Offer words 0..count-1 of v; each waits (bounded) for s_ready.
    task automatic send(input vec_t v, input int count);
        for (int i = 0; i < count; i++) begin
            int t;
            @(negedge clk);
            s_data  = word_of(v, i);
            s_valid = 1'b1;
            s_last  = (i == v.n - 1);
            s_bytes = (i == v.n - 1) ? v.bytes : 2'd3;
            t = 0;
            #1;
            while (!s_ready && t < 200) begin
                @(negedge clk);
                #1;
                t++;
            end
            if (!s_ready) begin
                checks++;
                errors++;
                $display("FAIL send_word%0d: s_ready stayed %0b expected 1", i, s_ready);
            end
            @(posedge clk);
            #1;
            cfg_out_size = ~v.os; // must not affect the running message
        end
    endtask

    task automatic queue_expect(input vec_t v, output logic [31:0] x);
        expq.delete();
        x = 32'd0;
        for (int i = 0; i < v.n; i++) begin
            beat_t b;
            b.w    = word_of(v, i);
            b.last = (i == v.n - 1) && (v.bytes != 2'd0);
            b.bn   = (i == v.n - 1) ? v.bytes : 2'd0;
            x      = x ^ b.w;
            expq.push_back(b);
        end
        if (v.bytes == 2'd0) begin
            beat_t p;
            p.w = 32'd0;
            p.last = 1'b1;
            p.bn = 2'd0;
            expq.push_back(p);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        logic [31:0]   x;
        logic [DW-1:0] snap;
        int rb, vb, sb, t, bad;
        @(negedge clk);
        cfg_out_size  = v.os;
        cur_stall_at  = v.stall_at;
        cur_stall_len = v.stall_len;
        queue_expect(v, x);
        rb = rst_pulses;
        vb = viol;
        sb = stream_err;
        send(v, v.n);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        t = 0;
        while (dig_valid !== 1'b1 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({tag, "_dig_valid"}, DW'(dig_valid), DW'(1));
        chk({tag, "_digest"}, dig_data, mk_digest(x, 16'(v.exp_fires), v.os, v.exp_bn));
        snap = dig_data;
        bad  = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            if (dig_valid !== 1'b1 || dig_data !== snap) bad++;
        end
        chk({tag, "_hold"}, DW'(bad), DW'(0));
        @(negedge clk);
        dig_ready = 1'b1;
        @(posedge clk);
        #1;
        dig_ready = 1'b0;
        chk({tag, "_valid_drop"}, DW'(dig_valid), DW'(0));
        chk({tag, "_idle_busy"}, DW'(busy), DW'(0));
        chk({tag, "_core_rst_pulses"}, DW'(rst_pulses - rb), DW'(1));
        chk({tag, "_core_words"}, DW'(m_fires), DW'(v.exp_fires));
        chk({tag, "_stream"}, DW'(stream_err - sb), DW'(0));
        chk({tag, "_stall_violation"}, DW'(viol - vb), DW'(0));
        chk({tag, "_byte_num"}, DW'(m_bn), DW'(v.exp_bn));
        chk({tag, "_out_size"}, DW'(m_os), DW'(v.os));
    endtask

    initial begin
        tbl[0] = '{32'h61626300, 1,  2'd3, 2'd3, 0,  0,  3, 1,  2'd3}; // "abc"
        tbl[1] = '{32'h61626364, 1,  2'd0, 2'd1, 0,  0,  1, 2,  2'd0}; // "abcd" + pad
        tbl[2] = '{32'h00010203, 50, 2'd0, 2'd2, 18, 30, 2, 51, 2'd0}; // 200 bytes, long stall
        tbl[3] = '{32'hdeadbeef, 3,  2'd0, 2'd0, 3,  6,  0, 4,  2'd0}; // pad under buffer_full
        tbl[4] = '{32'h11223344, 7,  2'd2, 2'd3, 2,  1,  0, 7,  2'd2}; // 2-byte tail, short stall
        tbl[5] = '{32'ha5a5c3c3, 2,  2'd1, 2'd2, 0,  0,  5, 2,  2'd1}; // 1-byte tail

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_reset", DW'(core_reset), DW'(1));
        chk("rst_s_ready", DW'(s_ready), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_dig_valid", DW'(dig_valid), DW'(0));
        chk("rst_dig_data", dig_data, '0);
        chk("rst_in_ready", DW'(core_in_ready), DW'(0));
        chk("rst_is_last", DW'(core_is_last), DW'(0));
        chk("rst_byte_num", DW'(core_byte_num), DW'(0));
        chk("rst_out_size", DW'(core_out_size), DW'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            run(tbl[k], $sformatf("vec%0d", k));
        end

        // Reset in the middle of a message, then a clean "abc".
        begin
            logic [31:0] xd;
            queue_expect(tbl[2], xd);
            send(tbl[2], 5);
            @(negedge clk);
            reset   = 1'b1;
            s_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst_busy", DW'(busy), DW'(0));
            chk("midrst_core_reset", DW'(core_reset), DW'(1));
            chk("midrst_dig_valid", DW'(dig_valid), DW'(0));
            chk("midrst_s_ready", DW'(s_ready), DW'(0));
            chk("midrst_in_ready", DW'(core_in_ready), DW'(0));
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            run(tbl[0], "abc_after_reset");
        end

`ifdef KECCAK_SEQ_TIMEOUT_EN
        // Core never produces a digest: watchdog fires 16 cycles into WAIT_OUT.
        begin
            logic [31:0] xt;
            int k;
            no_out = 1'b1;
            @(negedge clk);
            cfg_out_size = tbl[0].os;
            queue_expect(tbl[0], xt);
            send(tbl[0], 1);
            s_valid = 1'b0;
            k = 0;
            while (err_timeout !== 1'b1 && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("tmo_cycles", DW'(k), DW'(16));
            @(posedge clk);
            #1;
            chk("tmo_pulse_len", DW'(err_timeout), DW'(0));
            chk("tmo_idle", DW'(busy), DW'(0));
            chk("tmo_core_reset", DW'(core_reset), DW'(1));
            chk("tmo_no_digest", DW'(dig_valid), DW'(0));
            no_out = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
